uart_rx_stream: RTL and testbench
=================================

// Module: uart_rx_stream
// PURPOSE
//   UART receiver, 8N1. Samples async serial line rx, deserialises frames and
//   presents each byte on a valid/ready stream (StreamBus style, flattened).
//   Sits between the board RX pin (or a uart_tx loopback) and a stream consumer.
// PARAMETERS
//   CLK_HZ   8_000_000  clk frequency in Hz
//   BAUD     115_200    line bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer div, >=4)
//   SYNC_FF  2          rx synchroniser depth (>=2)
// PORTS
//   clk        in   1  single clock; all logic on rising edge
//   rst        in   1  synchronous, active-high reset
//   rx         in   1  async serial input, idle high
//   bus_valid  out  1  byte available on bus_data
//   bus_ready  in   1  consumer accepts byte when valid&&ready at clk edge
//   bus_data   out  8  received byte, LSB = first data bit
//   err        out  1  only when UART_RX_ERR_EN defined (see CONFIGURATION)
// BEHAVIOUR
//   Interface: one clock clk; reset rst is synchronous and active-high.
//   - Reset: bus_valid=0, bus_data=8'h00, err=0, FSM=IDLE, synchroniser flops=1.
//   - rx passes SYNC_FF flops before use; all timing below is on synced rx.
//   - Bit counter: $clog2(CLKS_PER_BIT) bits; HALF = CLKS_PER_BIT/2.
//   - FSM IDLE: synced rx 1->0 edge -> START, counter cleared.
//   - START: after HALF clocks sample rx; 0 -> DATA (counter cleared, idx=0);
//     1 -> false start, back to IDLE, nothing emitted.
//   - DATA: every CLKS_PER_BIT clocks sample rx into shift reg, LSB first;
//     after 8th sample -> STOP.
//   - STOP: after CLKS_PER_BIT clocks sample rx.
//     1 -> frame good: bus_data<=shift reg, bus_valid<=1 on the next edge; IDLE.
//     0 -> framing error: byte discarded, bus_valid unchanged; wait for rx=1,
//     then IDLE (no re-trigger on a held-low line/break).
//   - Stream: bus_valid held and bus_data stable until valid&&ready; then
//     bus_valid deasserts next edge unless a new byte completes on that same
//     edge, in which case new byte loads and bus_valid stays 1.
//   - Overrun: good frame completes while valid&&!ready -> new byte dropped,
//     held byte kept.
//   - Receiver never stalls rx sampling; bus_ready affects only output reg.
//   - Latency: bus_valid rises ~9.5 bit times + SYNC_FF+1 clocks after start edge.
//   - rst mid-frame: immediate return to reset state; partial byte lost;
//     next falling edge after reset starts a fresh frame.
// CONFIGURATION
//   UART_RX_ERR_EN defined: port err present; 1-clock pulse on framing error
//     (stop bit 0) or overrun (byte dropped); both same edge -> single pulse.
//   Undefined: no err port; errors silently dropped, behaviour otherwise same.
// TESTING (CLK_HZ=8e6, BAUD=115200 -> 69 clk/bit; bus_ready=1 unless noted)
//   - uart_tx loopback sends 8'hAB -> one bus_valid pulse, bus_data=8'hAB.
//   - Back-to-back 8'h00, 8'hFF, 8'h55 -> three valids, data in order, no err.
//   - bus_ready=0, send 8'h12 then 8'h34 -> bus_data holds 8'h12, err pulse
//     (if EN); raise ready -> one accept of 8'h12, then bus_valid=0.
//   - rx low pulse of 20 clocks (< HALF) -> no valid, FSM back to IDLE.
//   - Frame 8'hC3 with stop bit forced 0 -> no valid, err pulse (if EN);
//     following good 8'h5A received correctly.
//   - rst asserted mid-frame (after bit 3) -> bus_valid=0 immediately next edge,
//     next full frame 8'h7E received as 8'h7E.

Source files
------------

// File: rtl/uart_rx_stream_if.sv
// Byte stream carried from the UART receiver to its consumer: valid/ready handshake plus data.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface uart_rx_stream_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver that delivers each good byte on a valid/ready stream.
// Optional feature macro UART_RX_ERR_EN adds an err pulse for framing errors and overruns.
module uart_rx_stream #(
    parameter int CLK_HZ  = 8_000_000,
    parameter int BAUD    = 115_200,
    parameter int SYNC_FF = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
`ifdef UART_RX_ERR_EN
    output logic             err,
`endif
    uart_rx_stream_if.master bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic [SYNC_FF-1:0] sync_r;
    logic               rx_s;
    logic               rx_prev_r;
    logic [2:0]         state_r,  state_nx_s;
    logic [CNT_W-1:0]   cnt_r,    cnt_nx_s;
    logic [2:0]         idx_r,    idx_nx_s;
    logic [7:0]         shift_r,  shift_nx_s;
    logic               frame_good_s;
    logic               frame_err_s;
    logic               overrun_s;
    logic               valid_r;
    logic [7:0]         data_r;

    assign rx_s      = sync_r[SYNC_FF-1];
    assign overrun_s = frame_good_s & valid_r & ~bus.ready;
    assign bus.valid = valid_r;
    assign bus.data  = data_r;

    // Synchroniser chain for the asynchronous line, plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r    <= {SYNC_FF{1'b1}};
            rx_prev_r <= 1'b1;
        end else begin
            sync_r    <= {sync_r[SYNC_FF-2:0], rx};
            rx_prev_r <= rx_s;
        end
    end

    // Frame FSM next-state: every sample point is a terminal count of the bit-period counter.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r + CNT_W'(1);
        idx_nx_s     = idx_r;
        shift_nx_s   = shift_r;
        frame_good_s = 1'b0;
        frame_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = '0;
                if (rx_prev_r && !rx_s) begin
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nx_s   = '0;
                    idx_nx_s   = 3'd0;
                    state_nx_s = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nx_s   = '0;
                    shift_nx_s = {rx_s, shift_r[7:1]};
                    idx_nx_s   = idx_r + 3'd1;
                    state_nx_s = (idx_r == 3'd7) ? ST_STOP : ST_DATA;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nx_s     = '0;
                    frame_good_s = rx_s;
                    frame_err_s  = ~rx_s;
                    state_nx_s   = rx_s ? ST_IDLE : ST_BREAK;
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before another start edge can count.
                cnt_nx_s = '0;
                if (rx_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_BREAK;
                end
            end
            default: begin
                cnt_nx_s   = '0;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Frame FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            idx_r   <= idx_nx_s;
            shift_r <= shift_nx_s;
        end
    end

    // Output holding register: a new byte loads only if the slot is empty or being emptied now.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= 8'h00;
        end else if (frame_good_s && (!valid_r || bus.ready)) begin
            valid_r <= 1'b1;
            data_r  <= shift_r;
        end else if (valid_r && bus.ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

`ifdef UART_RX_ERR_EN
    // Single-cycle error pulse; simultaneous framing error and overrun merge into one pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= frame_err_s | overrun_s;
        end
    end
`else
    logic unused_err_s;
    assign unused_err_s = frame_err_s | overrun_s;
`endif
endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: a bit-banged UART transmitter feeds rx and a
// scoreboard compares every accepted byte against the bytes that were sent.
module tb_uart_rx_stream;
    localparam int CPB = 69;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   err_cnt = 0;
    int   err_base;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] e_b, g_b;

`ifdef UART_RX_ERR_EN
    logic err;
`endif

    uart_rx_stream_if bus ();

    uart_rx_stream #(.CLK_HZ(8_000_000), .BAUD(115_200), .SYNC_FF(2)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
`ifdef UART_RX_ERR_EN
        .err (err),
`endif
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Capture each handshake: valid&&ready seen at the falling edge completes on the next rise.
    always @(negedge clk) begin
        if (!rst && bus.valid && bus.ready) got_q.push_back(bus.data);
`ifdef UART_RX_ERR_EN
        if (!rst && err) err_cnt <= err_cnt + 1;
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int idle_clks);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (idle_clks) tick();
    endtask

    task automatic wait_outputs(input int n);
        for (int i = 0; i < 400 && got_q.size() < n; i++) tick();
        repeat (5) tick();
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        err_base = err_cnt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ready = 1'b1;
        rx = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_vec++;
        if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
        n_vec++;
        if (bus.data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", bus.data); end
`ifdef UART_RX_ERR_EN
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err); end
`endif
        rst = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_loopback();
        clear_sb();
        exp_q.push_back(8'hAB);
        send_frame(8'hAB, 1'b1, 20);
        wait_outputs(1);
        n_vec++;
        if (got_q.size() !== 1) begin n_err++; $display("FAIL loop_count got %0d exp 1", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_b = exp_q.pop_front(); g_b = got_q.pop_front(); n_vec++;
            if (g_b !== e_b) begin n_err++; $display("FAIL loop_data got %h exp %h", g_b, e_b); end
        end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1, 2);
        send_frame(8'hFF, 1'b1, 2);
        send_frame(8'h55, 1'b1, 20);
        wait_outputs(3);
        n_vec++;
        if (got_q.size() !== 3) begin n_err++; $display("FAIL b2b_count got %0d exp 3", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_b = exp_q.pop_front(); g_b = got_q.pop_front(); n_vec++;
            if (g_b !== e_b) begin n_err++; $display("FAIL b2b_data got %h exp %h", g_b, e_b); end
        end
`ifdef UART_RX_ERR_EN
        n_vec++;
        if (err_cnt - err_base !== 0) begin n_err++; $display("FAIL b2b_err got %0d exp 0", err_cnt - err_base); end
`endif
    endtask

    task automatic test_overrun();
        clear_sb();
        bus.ready = 1'b0;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 5);
        send_frame(8'h34, 1'b1, 20);
        @(negedge clk);
        n_vec++;
        if (bus.valid !== 1'b1) begin n_err++; $display("FAIL ovr_hold_valid got %b exp 1", bus.valid); end
        n_vec++;
        if (bus.data !== 8'h12) begin n_err++; $display("FAIL ovr_hold_data got %h exp 12", bus.data); end
        n_vec++;
        if (got_q.size() !== 0) begin n_err++; $display("FAIL ovr_early got %0d exp 0", got_q.size()); end
`ifdef UART_RX_ERR_EN
        n_vec++;
        if (err_cnt - err_base !== 1) begin n_err++; $display("FAIL ovr_err got %0d exp 1", err_cnt - err_base); end
`endif
        tick();
        bus.ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        n_vec++;
        if (bus.valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain_valid got %b exp 0", bus.valid); end
        n_vec++;
        if (got_q.size() !== 1) begin n_err++; $display("FAIL ovr_count got %0d exp 1", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_b = exp_q.pop_front(); g_b = got_q.pop_front(); n_vec++;
            if (g_b !== e_b) begin n_err++; $display("FAIL ovr_data got %h exp %h", g_b, e_b); end
        end
    endtask

    task automatic test_false_start();
        clear_sb();
        rx = 1'b0;
        repeat (20) tick();
        rx = 1'b1;
        repeat (60) tick();
        @(negedge clk);
        n_vec++;
        if (dut.state_r !== 3'b000) begin n_err++; $display("FAIL fs_state got %0d exp 0", dut.state_r); end
        repeat (700) tick();
        n_vec++;
        if (got_q.size() !== 0) begin n_err++; $display("FAIL fs_count got %0d exp 0", got_q.size()); end
        n_vec++;
        if (bus.valid !== 1'b0) begin n_err++; $display("FAIL fs_valid got %b exp 0", bus.valid); end
    endtask

    task automatic test_framing();
        clear_sb();
        send_frame(8'hC3, 1'b0, 30);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 20);
        wait_outputs(1);
        n_vec++;
        if (got_q.size() !== 1) begin n_err++; $display("FAIL frm_count got %0d exp 1", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_b = exp_q.pop_front(); g_b = got_q.pop_front(); n_vec++;
            if (g_b !== e_b) begin n_err++; $display("FAIL frm_data got %h exp %h", g_b, e_b); end
        end
`ifdef UART_RX_ERR_EN
        n_vec++;
        if (err_cnt - err_base !== 1) begin n_err++; $display("FAIL frm_err got %0d exp 1", err_cnt - err_base); end
`endif
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        clear_sb();
        bus.ready = 1'b0;
        send_frame(8'h11, 1'b1, 10);
        @(negedge clk);
        n_vec++;
        if (bus.valid !== 1'b1) begin n_err++; $display("FAIL rmf_pre_valid got %b exp 1", bus.valid); end
        b = 8'h7E;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = 1'b1;
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_vec++;
        if (bus.valid !== 1'b0) begin n_err++; $display("FAIL rmf_valid got %b exp 0", bus.valid); end
        n_vec++;
        if (bus.data !== 8'h00) begin n_err++; $display("FAIL rmf_data_clr got %h exp 00", bus.data); end
        tick();
        rst = 1'b0;
        bus.ready = 1'b1;
        repeat (3 * CPB) tick();
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 20);
        wait_outputs(1);
        n_vec++;
        if (got_q.size() !== 1) begin n_err++; $display("FAIL rmf_count got %0d exp 1", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e_b = exp_q.pop_front(); g_b = got_q.pop_front(); n_vec++;
            if (g_b !== e_b) begin n_err++; $display("FAIL rmf_data got %h exp %h", g_b, e_b); end
        end
    endtask

    initial begin
        bus.ready = 1'b1;
        test_reset();
        test_loopback();
        test_back_to_back();
        test_overrun();
        test_false_start();
        test_framing();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
